// File: rtl/sw_debounce_reader.sv
// Two-flop synchronizer plus per-bit debounce for slide switches, publishing each
// debounced change as a valid/ready event carrying the new word and a sticky change mask.
module sw_debounce_reader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             chg_valid,
  output logic [WIDTH-1:0] chg_data,
  output logic [WIDTH-1:0] chg_mask,
  input  logic             chg_ready,
  output logic             chg_overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [WIDTH-1:0]         s1_q;
  logic [WIDTH-1:0]         s_q;
  logic [WIDTH-1:0]         stable_q;
  logic [WIDTH-1:0]         stable_d;
  logic [WIDTH-1:0]         flip_s;
  logic [WIDTH-1:0][CW-1:0] cnt_q;
  logic [WIDTH-1:0][CW-1:0] cnt_d;
  state_t                   state_q;
  state_t                   state_d;
  logic [WIDTH-1:0]         data_q;
  logic [WIDTH-1:0]         data_d;
  logic [WIDTH-1:0]         mask_q;
  logic [WIDTH-1:0]         mask_d;
  logic                     ovr_q;
  logic                     ovr_d;

  // Per-bit debounce: a bit is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    flip_s   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (s_q[i] == stable_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = s_q[i];
        cnt_d[i]    = {CW{1'b0}};
        flip_s[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Event register next-state: consume and reload may happen on the same edge.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (|flip_s) begin
          state_d = PENDING;
          data_d  = stable_d;
          mask_d  = flip_s;
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        if (chg_ready) begin
          if (|flip_s) begin
            data_d = stable_d;
            mask_d = flip_s;
          end else begin
            state_d = IDLE;
            mask_d  = {WIDTH{1'b0}};
          end
        end else begin
          if (|flip_s) begin
            // Unconsumed event absorbs the new change; mask accumulates.
            data_d = stable_d;
            mask_d = mask_q | flip_s;
            ovr_d  = 1'b1;
          end else begin
            state_d = PENDING;
          end
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = {WIDTH{1'b0}};
      end
    endcase
  end

  // State registers; reset baseline is all switches low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= {WIDTH{1'b0}};
      s_q      <= {WIDTH{1'b0}};
      stable_q <= {WIDTH{1'b0}};
      cnt_q    <= '0;
      state_q  <= IDLE;
      data_q   <= {WIDTH{1'b0}};
      mask_q   <= {WIDTH{1'b0}};
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= sw;
      s_q      <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sw_stable   = stable_q;
  assign chg_valid   = (state_q == PENDING);
  assign chg_data    = data_q;
  assign chg_mask    = mask_q;
  assign chg_overrun = ovr_q;

endmodule

// File: tb/tb_sw_debounce_reader.sv
// Randomized and directed bench for sw_debounce_reader against a sample-window reference model.
module tb_sw_debounce_reader;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sw;
  logic [W-1:0] sw_stable;
  logic         chg_valid;
  logic [W-1:0] chg_data;
  logic [W-1:0] chg_mask;
  logic         chg_ready;
  logic         chg_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history of sampled sw values plus the event state.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_stable;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [W-1:0] m_mask;
  logic         m_ovr;

  sw_debounce_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sw_stable(sw_stable),
    .chg_valid(chg_valid), .chg_data(chg_data), .chg_mask(chg_mask),
    .chg_ready(chg_ready), .chg_overrun(chg_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < D + 2; k++) m_hist.push_back({W{1'b0}});
    m_stable = '0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_mask   = '0;
    m_ovr    = 1'b0;
  endtask

  // A bit flips when the synchronized value (sample from two edges ago) has
  // disagreed with the stable level for the last D evaluations.
  task automatic model_edge(input logic [W-1:0] sw_in, input logic rdy);
    logic [W-1:0] flip;
    logic [W-1:0] nstab;
    bit           all_diff;
    m_hist.push_back(sw_in);
    void'(m_hist.pop_front());
    flip = '0;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < D; k++)
        if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
      flip[i] = all_diff;
    end
    nstab = m_stable ^ flip;
    if (!m_valid) begin
      if (flip != 0) begin
        m_valid = 1'b1; m_data = nstab; m_mask = flip;
      end
    end else if (rdy) begin
      if (flip != 0) begin
        m_data = nstab; m_mask = flip;
      end else begin
        m_valid = 1'b0; m_mask = '0;
      end
    end else if (flip != 0) begin
      m_data = nstab; m_mask = m_mask | flip; m_ovr = 1'b1;
    end
    m_stable = nstab;
  endtask

  task automatic compare_model();
    check_eq("sw_stable", 32'(sw_stable), 32'(m_stable));
    check_eq("chg_valid", 32'(chg_valid), 32'(m_valid));
    check_eq("chg_data", 32'(chg_data), 32'(m_data));
    check_eq("chg_mask", 32'(chg_mask), 32'(m_mask));
    check_eq("chg_overrun", 32'(chg_overrun), 32'(m_ovr));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge(sw, chg_ready);
      #1;
      compare_model();
    end
  endtask

  task automatic do_reset(input logic [W-1:0] sw_init);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sw    = sw_init;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    compare_model();
  endtask

  initial begin
    rst_n     = 1'b0;
    sw        = '0;
    chg_ready = 1'b0;
    model_reset();

    // Reset and latency
    do_reset(8'h00);
    step(3);
    check_eq("idle_valid", 32'(chg_valid), 32'd0);
    sw = 8'h55;
    step(5);
    check_eq("lat_early_stable", 32'(sw_stable), 32'h00);
    step(1);
    check_eq("lat_stable", 32'(sw_stable), 32'h55);
    check_eq("lat_valid", 32'(chg_valid), 32'd1);
    check_eq("lat_data", 32'(chg_data), 32'h55);
    check_eq("lat_mask", 32'(chg_mask), 32'h55);

    // Bounce rejection on bit 0
    do_reset(8'h00);
    step(2);
    sw = 8'h01; step(3);
    sw = 8'h00; step(1);
    sw = 8'h01; step(5);
    check_eq("bounce_early", 32'(sw_stable[0]), 32'd0);
    check_eq("bounce_noevt", 32'(chg_valid), 32'd0);
    step(1);
    check_eq("bounce_rise", 32'(sw_stable[0]), 32'd1);
    check_eq("bounce_mask", 32'(chg_mask), 32'h01);
    step(4);

    // Handshake
    chg_ready = 1'b1; step(1); chg_ready = 1'b0;
    check_eq("hs_valid", 32'(chg_valid), 32'd0);
    check_eq("hs_mask", 32'(chg_mask), 32'h00);
    check_eq("hs_data", 32'(chg_data), 32'h01);
    check_eq("hs_ovr", 32'(chg_overrun), 32'd0);

    // Overrun merge
    do_reset(8'h00);
    sw = 8'h01; step(8);
    sw = 8'h03; step(8);
    check_eq("ovr_data", 32'(chg_data), 32'h03);
    check_eq("ovr_mask", 32'(chg_mask), 32'h03);
    check_eq("ovr_flag", 32'(chg_overrun), 32'd1);
    chg_ready = 1'b1; step(1); chg_ready = 1'b0;
    check_eq("ovr_consumed", 32'(chg_valid), 32'd0);
    check_eq("ovr_sticky", 32'(chg_overrun), 32'd1);

    // Simultaneous consume and load
    do_reset(8'h00);
    chg_ready = 1'b1;
    sw = 8'h01; step(1);
    sw = 8'h03; step(5);
    check_eq("b2b_first_mask", 32'(chg_mask), 32'h01);
    check_eq("b2b_first_data", 32'(chg_data), 32'h01);
    step(1);
    check_eq("b2b_second_mask", 32'(chg_mask), 32'h02);
    check_eq("b2b_second_data", 32'(chg_data), 32'h03);
    check_eq("b2b_valid", 32'(chg_valid), 32'd1);
    step(1);
    check_eq("b2b_drained", 32'(chg_valid), 32'd0);
    check_eq("b2b_ovr", 32'(chg_overrun), 32'd0);
    chg_ready = 1'b0;

    // Reset mid-operation, asynchronous to clk
    do_reset(8'h00);
    sw = 8'h01; step(7);
    sw = 8'h05; step(4);
    check_eq("mid_pending", 32'(chg_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_stable", 32'(sw_stable), 32'h00);
    check_eq("arst_valid", 32'(chg_valid), 32'd0);
    check_eq("arst_data", 32'(chg_data), 32'h00);
    check_eq("arst_mask", 32'(chg_mask), 32'h00);
    check_eq("arst_ovr", 32'(chg_overrun), 32'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
    sw = 8'h00;

    // Randomized stimulus
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)
        sw = sw ^ (8'(1) << $urandom_range(0, W - 1));
      chg_ready = ($urandom_range(0, 2) == 0);
      step(1);
      if (c == 1500) begin
        do_reset(8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_debounce_reader.md
# sw_debounce_reader

Input-side companion to the switch-to-LED path. It synchronizes and debounces the board slide switches, then publishes a stable switch word. Each debounced change is reported as a valid/ready event carrying the new value and a mask of the bits that changed. It sits between the raw switch pins and any consumer logic (LED driver, register file, control FSM) that must never see metastable or bouncing inputs.

## Interface
Parameters:
- WIDTH, 8, number of switch bits.
- DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronized bit must differ from its stable value before the new level is accepted; minimum 2. Counter width is clog2(DEBOUNCE_CYCLES).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  WIDTH  raw switch pins, asynchronous to clk.
- sw_stable  out  WIDTH  debounced switch word.
- chg_valid  out  1  a change event is pending.
- chg_data  out  WIDTH  sw_stable value at the most recent change.
- chg_mask  out  WIDTH  bits that changed since the last consumed event (sticky OR).
- chg_ready  in  1  consumer accepts the event when chg_valid && chg_ready.
- chg_overrun  out  1  sticky flag: a change merged into an unconsumed event; cleared only by reset.

## Operation
- Synchronizer: two flip-flops per bit, sw -> s1 -> s. Only s is used downstream.
- Debounce, per bit, with an independent counter cnt[i]:
  - If s[i] == sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any glitch back to the stable level restarts the count from 0. Counters never wrap past DEBOUNCE_CYCLES-1.
- flip[i] = bit i updates sw_stable this cycle. The event is any(flip).
- Event register, two states: IDLE (chg_valid=0) and PENDING (chg_valid=1).
  - IDLE, any(flip): go to PENDING. chg_data <= new sw_stable. chg_mask <= flip.
  - PENDING, chg_ready=1, no flip: go to IDLE. chg_mask <= 0. chg_data holds.
  - PENDING, chg_ready=1, any(flip): stay PENDING. chg_data <= new sw_stable. chg_mask <= flip. Old event consumed, new one loaded in the same cycle. No overrun.
  - PENDING, chg_ready=0, any(flip): stay PENDING. chg_data <= new sw_stable. chg_mask <= chg_mask | flip. chg_overrun <= 1.
  - PENDING, chg_ready=0, no flip: hold everything.
- A bit that toggles twice before consumption stays set in chg_mask even if its final value equals the pre-event value.
- chg_ready is ignored in IDLE.

## Timing
- Reset values (asynchronous, while rst_n=0): s1, s, sw_stable, cnt, chg_data, chg_mask all 0; chg_valid 0; chg_overrun 0.
- The reset baseline is all switches low. Switches held high through reset release produce a normal change event after debounce.
- Latency: if sw[i] changes before edge E and stays stable, s[i] is updated at edge E+1. sw_stable[i] and chg_valid update at edge E+1+DEBOUNCE_CYCLES.
- chg_valid and chg_data update on the same edge as sw_stable; there is no extra pipeline stage.
- Handshake: a transfer occurs on a rising edge with chg_valid && chg_ready. chg_valid deasserts on that edge unless a new flip is loaded.
- Throughput: one event per cycle when chg_ready is held high.
- Reset mid-debounce or mid-event discards all state; no event survives reset.

## Test plan
Run with DEBOUNCE_CYCLES=4, WIDTH=8.
- Reset and latency: hold rst_n=0, then release with sw=8'h00. Outputs stay 0 and chg_valid=0. Change sw to 8'h55 just before edge E. At edge E+5: sw_stable=8'h55, chg_valid=1, chg_data=8'h55, chg_mask=8'h55.
- Bounce rejection: with sw_stable=8'h00, toggle sw[0] high for 3 cycles, low for 1, then high steadily. sw_stable[0] rises exactly 5 edges after the final rise (2-flop sync plus 4-cycle debounce). Exactly one event is produced.
- Handshake: with an event pending, hold chg_ready=1 for one edge. chg_valid drops, chg_mask becomes 0, chg_data is retained, chg_overrun stays 0.
- Overrun merge: with chg_ready=0, sequence 8'h01 then 8'h03. Result: chg_data=8'h03, chg_mask=8'h03, chg_overrun=1. Then pulse chg_ready: chg_valid=0, chg_overrun stays 1.
- Simultaneous consume and load: with chg_ready=1, debounce two different bits completing on consecutive cycles. Two distinct events are accepted back-to-back, each with a single-bit mask, and chg_overrun=0.
- Reset mid-operation: assert rst_n=0 while a debounce count is 2 and an event is pending. All outputs go to 0 immediately, with no dependence on clk.
